// File: rtl/vending_fsm_param.sv
// Parametrised vending controller: price table, reject, cancel-refund and serial change return.
// Latency: requests take effect on the next edge; dispense lasts 1 cycle, then 1 change cycle per credit unit.
// Backpressure: busy is high in DISPENSE/CHANGE; coins then are rejected, selections and cancels dropped.
module vending_fsm_param #(
  parameter int CREDIT_W = 5,
  parameter int COIN_W   = 3,
  parameter int N_PROD   = 4,
  parameter int PRICE_W  = 5,
  parameter logic [N_PROD*PRICE_W-1:0] PRICES = {5'd7, 5'd5, 5'd4, 5'd3},
  parameter bit CHANGE_EN = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        coin_valid,
  input  logic [COIN_W-1:0]           coin_val,
  input  logic                        sel_valid,
  input  logic [$clog2(N_PROD)-1:0]   sel_idx,
  input  logic                        cancel,
  output logic [CREDIT_W-1:0]         credit,
  output logic                        dispense,
  output logic [$clog2(N_PROD)-1:0]   prod,
  output logic                        change_pulse,
  output logic                        busy,
  output logic                        reject
);

  localparam int IW = $clog2(N_PROD);

  typedef enum logic [1:0] {
    S_CREDIT   = 2'd0,
    S_DISPENSE = 2'd1,
    S_CHANGE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [IW-1:0]       prod_q, prod_d;
  logic                reject_q, reject_d;

  logic [PRICE_W-1:0]  price;
  logic                idx_ok;
  logic [CREDIT_W-1:0] price_ext;
  logic                sel_afford;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;

  // Indices beyond N_PROD never match, which is how an out-of-range selection is flagged.
  always_comb begin
    price  = '0;
    idx_ok = 1'b0;
    for (int i = 0; i < N_PROD; i++) begin
      if (sel_idx == IW'(i)) begin
        price  = PRICES[i*PRICE_W +: PRICE_W];
        idx_ok = 1'b1;
      end
    end
  end

  assign price_ext  = CREDIT_W'(price);
  assign sel_afford = idx_ok && (price_ext <= credit_q);
  assign coin_sum   = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
  assign coin_fits  = ~coin_sum[CREDIT_W];

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    prod_d   = prod_q;
    reject_d = 1'b0;
    case (state_q)
      S_CREDIT: begin
        if (cancel && (credit_q != '0)) begin
          state_d  = S_CHANGE;
          reject_d = coin_valid;
        end else if (sel_valid && sel_afford) begin
          credit_d = credit_q - price_ext;
          prod_d   = sel_idx;
          state_d  = S_DISPENSE;
          reject_d = coin_valid;
        end else begin
          // A refused selection still lets a coin in the same cycle be credited.
          reject_d = sel_valid;
          if (coin_valid && (coin_val != '0)) begin
            if (coin_fits) credit_d = coin_sum[CREDIT_W-1:0];
            else           reject_d = 1'b1;
          end
        end
      end
      S_DISPENSE: begin
        reject_d = coin_valid;
        state_d  = (CHANGE_EN && (credit_q != '0)) ? S_CHANGE : S_CREDIT;
      end
      S_CHANGE: begin
        reject_d = coin_valid;
        if (credit_q > CREDIT_W'(1)) begin
          credit_d = credit_q - CREDIT_W'(1);
        end else begin
          credit_d = '0;
          state_d  = S_CREDIT;
        end
      end
      default: state_d = S_CREDIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_CREDIT;
      credit_q <= '0;
      prod_q   <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      prod_q   <= prod_d;
      reject_q <= reject_d;
    end
  end

  assign credit       = credit_q;
  assign prod         = prod_q;
  assign reject       = reject_q;
  assign dispense     = (state_q == S_DISPENSE);
  assign change_pulse = (state_q == S_CHANGE);
  assign busy         = (state_q == S_DISPENSE) || (state_q == S_CHANGE);

endmodule

// File: tb/tb_vending_fsm_param.sv
// Bench for vending_fsm_param: default, 3-product and change-disabled instances share one stimulus.
module tb_vending_fsm_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid;
  logic [2:0] coin_val;
  logic       sel_valid;
  logic [1:0] sel_idx;
  logic       cancel;

  logic [4:0] credit, credit3, credit_nc;
  logic       dispense, dispense3, dispense_nc;
  logic [1:0] prod, prod3, prod_nc;
  logic       change_pulse, change_pulse3, change_pulse_nc;
  logic       busy, busy3, busy_nc;
  logic       reject, reject3, reject_nc;

  int checks = 0;
  int errors = 0;
  int step   = 0;

  always #5 clk = ~clk;

  vending_fsm_param u_dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_val(coin_val),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel),
    .credit(credit), .dispense(dispense), .prod(prod),
    .change_pulse(change_pulse), .busy(busy), .reject(reject)
  );

  vending_fsm_param #(.N_PROD(3), .PRICES({5'd5, 5'd4, 5'd3})) u_dut3 (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_val(coin_val),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel),
    .credit(credit3), .dispense(dispense3), .prod(prod3),
    .change_pulse(change_pulse3), .busy(busy3), .reject(reject3)
  );

  vending_fsm_param #(.CHANGE_EN(1'b0)) u_nc (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_val(coin_val),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel),
    .credit(credit_nc), .dispense(dispense_nc), .prod(prod_nc),
    .change_pulse(change_pulse_nc), .busy(busy_nc), .reject(reject_nc)
  );

  typedef struct {
    logic       coin_v;
    logic [2:0] coin;
    logic       sel_v;
    logic [1:0] idx;
    logic       cncl;
    logic [4:0] e_credit;
    logic       e_disp;
    logic       e_chg;
    logic       e_busy;
    logic       e_rej;
    logic [1:0] e_prod;
  } vec_t;

  vec_t tbl[24];
  vec_t exp_q[$];

  function automatic vec_t v(input logic cv, input logic [2:0] cval, input logic sv,
                             input logic [1:0] sidx, input logic cn, input logic [4:0] ecr,
                             input logic ed, input logic ech, input logic eb, input logic er,
                             input logic [1:0] ep);
    vec_t t;
    t.coin_v = cv;  t.coin = cval; t.sel_v = sv; t.idx = sidx; t.cncl = cn;
    t.e_credit = ecr; t.e_disp = ed; t.e_chg = ech; t.e_busy = eb; t.e_rej = er; t.e_prod = ep;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, step, act, exp);
    end
  endtask

  // Pops the oldest expectation and compares it with the default and 3-product instances.
  task automatic check_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard step %0d: no expectation queued", step);
      return;
    end
    e = exp_q.pop_front();
    check("credit", credit, e.e_credit);
    check("dispense", dispense, e.e_disp);
    check("change_pulse", change_pulse, e.e_chg);
    check("busy", busy, e.e_busy);
    check("reject", reject, e.e_rej);
    check("prod", prod, e.e_prod);
    check("credit3", credit3, e.e_credit);
    check("change_pulse3", change_pulse3, e.e_chg);
    check("reject3", reject3, e.e_rej);
    check("dispense3", dispense3, e.e_disp);
  endtask

  task automatic apply(input vec_t t);
    coin_valid = t.coin_v;
    coin_val   = t.coin;
    sel_valid  = t.sel_v;
    sel_idx    = t.idx;
    cancel     = t.cncl;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    coin_valid = 1'b0;
    coin_val   = '0;
    sel_valid  = 1'b0;
    sel_idx    = '0;
    cancel     = 1'b0;
    step++;
    check_out();
  endtask

  // Refund of k units: pulses 0..k-1 show credit k..1; a coin during the second pulse is rejected.
  task automatic refund(input int k, input logic coin_with_cancel, input logic [1:0] ep);
    apply(v(coin_with_cancel, 3'd1, 1'b0, 2'd0, 1'b1, 5'(k), 1'b0, 1'b1, 1'b1, coin_with_cancel, ep));
    for (int p = 1; p < k; p++)
      apply(v(p == 2, 3'd1, 1'b0, 2'd0, 1'b0, 5'(k - p), 1'b0, 1'b1, 1'b1, p == 2, ep));
    apply(v(1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ep));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_credit"}, {credit, credit3, credit_nc}, 15'd0);
    check({tag, "_dispense"}, {dispense, dispense3, dispense_nc}, 3'd0);
    check({tag, "_change"}, {change_pulse, change_pulse3, change_pulse_nc}, 3'd0);
    check({tag, "_busy"}, {busy, busy3, busy_nc}, 3'd0);
    check({tag, "_reject"}, {reject, reject3, reject_nc}, 3'd0);
    check({tag, "_prod"}, {prod, prod3, prod_nc}, 6'd0);
  endtask

  initial begin
    reset = 1'b1;
    coin_valid = 1'b0; coin_val = '0; sel_valid = 1'b0; sel_idx = '0; cancel = 1'b0;

    //            cv cval sv idx cn  credit d  c  b  r  prod
    tbl[0]  = v(1, 3'd2, 0, 2'd0, 0, 5'd2,  0, 0, 0, 0, 2'd0);
    tbl[1]  = v(1, 3'd2, 0, 2'd0, 0, 5'd4,  0, 0, 0, 0, 2'd0);
    tbl[2]  = v(1, 3'd1, 0, 2'd0, 0, 5'd5,  0, 0, 0, 0, 2'd0);
    tbl[3]  = v(0, 3'd0, 1, 2'd1, 0, 5'd1,  1, 0, 1, 0, 2'd1);
    tbl[4]  = v(0, 3'd0, 0, 2'd0, 0, 5'd1,  0, 1, 1, 0, 2'd1);
    tbl[5]  = v(0, 3'd0, 0, 2'd0, 0, 5'd0,  0, 0, 0, 0, 2'd1);
    tbl[6]  = v(1, 3'd2, 0, 2'd0, 0, 5'd2,  0, 0, 0, 0, 2'd1);
    tbl[7]  = v(0, 3'd0, 1, 2'd3, 0, 5'd2,  0, 0, 0, 1, 2'd1);
    tbl[8]  = v(0, 3'd0, 0, 2'd0, 0, 5'd2,  0, 0, 0, 0, 2'd1);
    tbl[9]  = v(1, 3'd3, 1, 2'd0, 0, 5'd5,  0, 0, 0, 1, 2'd1);
    tbl[10] = v(1, 3'd2, 1, 2'd0, 0, 5'd2,  1, 0, 1, 1, 2'd0);
    tbl[11] = v(0, 3'd0, 0, 2'd0, 0, 5'd2,  0, 1, 1, 0, 2'd0);
    tbl[12] = v(0, 3'd0, 0, 2'd0, 0, 5'd1,  0, 1, 1, 0, 2'd0);
    tbl[13] = v(0, 3'd0, 0, 2'd0, 0, 5'd0,  0, 0, 0, 0, 2'd0);
    tbl[14] = v(0, 3'd0, 0, 2'd0, 1, 5'd0,  0, 0, 0, 0, 2'd0);
    tbl[15] = v(1, 3'd7, 0, 2'd0, 0, 5'd7,  0, 0, 0, 0, 2'd0);
    tbl[16] = v(1, 3'd7, 0, 2'd0, 0, 5'd14, 0, 0, 0, 0, 2'd0);
    tbl[17] = v(1, 3'd7, 0, 2'd0, 0, 5'd21, 0, 0, 0, 0, 2'd0);
    tbl[18] = v(1, 3'd7, 0, 2'd0, 0, 5'd28, 0, 0, 0, 0, 2'd0);
    tbl[19] = v(1, 3'd2, 0, 2'd0, 0, 5'd30, 0, 0, 0, 0, 2'd0);
    tbl[20] = v(1, 3'd3, 0, 2'd0, 0, 5'd30, 0, 0, 0, 1, 2'd0);
    tbl[21] = v(1, 3'd0, 0, 2'd0, 0, 5'd30, 0, 0, 0, 0, 2'd0);
    tbl[22] = v(1, 3'd1, 0, 2'd0, 0, 5'd31, 0, 0, 0, 0, 2'd0);
    tbl[23] = v(1, 3'd1, 0, 2'd0, 0, 5'd31, 0, 0, 0, 1, 2'd0);

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    reset = 1'b0;

    for (int i = 0; i < 24; i++) apply(tbl[i]);

    // Full-credit refund; the coin alongside the cancel is refused.
    refund(31, 1'b1, 2'd0);

    apply(v(1, 3'd3, 0, 2'd0, 0, 5'd3, 0, 0, 0, 0, 2'd0));
    refund(3, 1'b0, 2'd0);

    // Asynchronous reset two pulses into a 4-unit refund.
    apply(v(1, 3'd4, 0, 2'd0, 0, 5'd4, 0, 0, 0, 0, 2'd0));
    apply(v(0, 3'd0, 0, 2'd0, 1, 5'd4, 0, 1, 1, 0, 2'd0));
    apply(v(0, 3'd0, 0, 2'd0, 0, 5'd3, 0, 1, 1, 0, 2'd0));
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) apply(v(0, 3'd0, 0, 2'd0, 0, 5'd0, 0, 0, 0, 0, 2'd0));

    // Change-disabled instance keeps the remainder as credit.
    apply(v(1, 3'd6, 0, 2'd0, 0, 5'd6, 0, 0, 0, 0, 2'd0));
    check("nc_credit_loaded", credit_nc, 5'd6);
    apply(v(0, 3'd0, 1, 2'd2, 0, 5'd1, 1, 0, 1, 0, 2'd2));
    check("nc_dispense", dispense_nc, 1'b1);
    check("nc_credit_after_sale", credit_nc, 5'd1);
    check("nc_prod", prod_nc, 2'd2);
    apply(v(0, 3'd0, 0, 2'd0, 0, 5'd1, 0, 1, 1, 0, 2'd2));
    check("nc_change_pulse", change_pulse_nc, 1'b0);
    check("nc_busy", busy_nc, 1'b0);
    check("nc_credit_kept", credit_nc, 5'd1);
    apply(v(0, 3'd0, 0, 2'd0, 0, 5'd0, 0, 0, 0, 0, 2'd2));
    check("nc_credit_still", credit_nc, 5'd1);
    check("nc_change_idle", change_pulse_nc, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
